// File: rtl/traffic_light_param_pkg.sv
// Shared definitions for the highway/farm-road intersection controller:
// FSM state codes, lamp encodings and the per-state lamp decode.
package traffic_pkg;

    typedef enum logic [2:0] {
        HGRN   = 3'd0,
        HYEL   = 3'd1,
        CLR_HF = 3'd2,
        FGRN   = 3'd3,
        FYEL   = 3'd4,
        CLR_FH = 3'd5,
        FLASH  = 3'd6
    } state_t;

    // One-hot lamp encoding: [2]=red, [1]=yellow, [0]=green.
    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    typedef struct packed {
        logic [2:0] highway;
        logic [2:0] farm;
    } lamps_t;

    // Lamp pattern for a state; blink_off selects the dark half of the flash cycle.
    function automatic lamps_t lamp_decode(input state_t st, input logic blink_off);
        lamps_t l;
        l.highway = LAMP_RED;
        l.farm    = LAMP_RED;
        case (st)
            HGRN: l.highway = LAMP_GRN;
            HYEL: l.highway = LAMP_YEL;
            FGRN: l.farm    = LAMP_GRN;
            FYEL: l.farm    = LAMP_YEL;
            FLASH: begin
                l.highway = blink_off ? LAMP_OFF : LAMP_YEL;
                l.farm    = blink_off ? LAMP_OFF : LAMP_RED;
            end
            default: ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/traffic_light_param_if.sv
// Sensor inputs and lamp/debug outputs of the intersection controller.
// The controller uses the slave modport; the environment driving the
// sensors and observing the lamps uses the master modport.
interface traffic_light_param_if;

    logic       sensor;
    logic       flash_en;
    logic [2:0] light_highway;
    logic [2:0] light_farm;
    logic [2:0] state_o;

    modport master (
        output sensor,
        output flash_en,
        input  light_highway,
        input  light_farm,
        input  state_o
    );

    modport slave (
        input  sensor,
        input  flash_en,
        output light_highway,
        output light_farm,
        output state_o
    );

endinterface

// File: rtl/traffic_light_param_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input; clears to 0.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the raw input through two flops to settle metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/traffic_light_param.sv
// Highway/farm-road intersection controller with parameterised phase
// durations, all-red clearance, bounded farm green and a flashing mode.
// Lamp outputs are registered from the next-state decode so they change
// on the same edge as state_o.
module traffic_light_param
    import traffic_pkg::*;
#(
    parameter int unsigned TW             = 16,
    parameter int unsigned HW_MIN_GREEN   = 600,
    parameter int unsigned FARM_MIN_GREEN = 100,
    parameter int unsigned FARM_MAX_GREEN = 300,
    parameter int unsigned YEL_TIME       = 30,
    parameter int unsigned CLR_TIME       = 10,
    parameter int unsigned FLASH_HALF     = 50
) (
    input  logic                 clk,
    input  logic                 rst_n,
    traffic_light_param_if.slave tl
);

    // Last timer value of each phase: a phase of D cycles ends at D-1.
    localparam logic [TW-1:0] HW_MIN_LAST   = TW'(HW_MIN_GREEN - 1);
    localparam logic [TW-1:0] FARM_MIN_LAST = TW'(FARM_MIN_GREEN - 1);
    localparam logic [TW-1:0] FARM_MAX_LAST = TW'(FARM_MAX_GREEN - 1);
    localparam logic [TW-1:0] YEL_LAST      = TW'(YEL_TIME - 1);
    localparam logic [TW-1:0] CLR_LAST      = TW'(CLR_TIME - 1);
    localparam logic [TW-1:0] FLASH_LAST    = TW'(FLASH_HALF - 1);

    logic          sensor_s;
    logic          flash_s;
    state_t        state;
    state_t        state_next;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_next;
    logic          blink;
    logic          blink_next;
    logic          flash_wrap;
    lamps_t        lamps_next;

    sync2 u_sync_sensor (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (tl.sensor),
        .q     (sensor_s)
    );

    sync2 u_sync_flash (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (tl.flash_en),
        .q     (flash_s)
    );

    // Next-state selection; flash_s takes priority over sensor_s everywhere.
    always_comb begin
        state_next = state;
        case (state)
            HGRN: begin
                if (flash_s || (sensor_s && (timer >= HW_MIN_LAST)))
                    state_next = HYEL;
            end
            HYEL: begin
                if (timer == YEL_LAST)
                    state_next = CLR_HF;
            end
            CLR_HF: begin
                if (timer == CLR_LAST)
                    state_next = flash_s ? FLASH : FGRN;
            end
            FGRN: begin
                if (flash_s || (!sensor_s && (timer >= FARM_MIN_LAST)) ||
                    (timer == FARM_MAX_LAST))
                    state_next = FYEL;
            end
            FYEL: begin
                if (timer == YEL_LAST)
                    state_next = CLR_FH;
            end
            CLR_FH: begin
                if (timer == CLR_LAST)
                    state_next = flash_s ? FLASH : HGRN;
            end
            FLASH: begin
                if (!flash_s)
                    state_next = CLR_FH;
            end
            default: state_next = HGRN;
        endcase
    end

    // Timer, blink phase and lamp decode for the state about to be entered.
    always_comb begin
        flash_wrap = (state == FLASH) && (timer == FLASH_LAST);
        timer_next = timer + 1'b1;
        blink_next = 1'b0;
        if (state_next != state) begin
            timer_next = '0;
        end else if (flash_wrap) begin
            // FLASH has no exit deadline, so its timer counts half-periods
            // instead of the whole phase, which also keeps it from wrapping.
            timer_next = '0;
        end else if ((state == HGRN) && (timer >= HW_MIN_LAST)) begin
            // Hold once minimum green is met: the >= test stays true and an
            // idle highway green can last indefinitely without wrapping.
            timer_next = timer;
        end
        if ((state_next == FLASH) && (state == FLASH))
            blink_next = flash_wrap ? ~blink : blink;
        lamps_next = lamp_decode(state_next, blink_next);
    end

    // State, timer, blink phase and lamp registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= HGRN;
            timer            <= '0;
            blink            <= 1'b0;
            tl.light_highway <= LAMP_GRN;
            tl.light_farm    <= LAMP_RED;
        end else begin
            state            <= state_next;
            timer            <= timer_next;
            blink            <= blink_next;
            tl.light_highway <= lamps_next.highway;
            tl.light_farm    <= lamps_next.farm;
        end
    end

    assign tl.state_o = state;

endmodule

// File: tb/tb_traffic_light_param.sv
// Directed and randomised checks of traffic_light_param with short phase
// durations. Expected phase sequences and lengths are written out by hand.
module tb_traffic_light_param;

    localparam logic [2:0] S_HGRN   = 3'd0;
    localparam logic [2:0] S_HYEL   = 3'd1;
    localparam logic [2:0] S_CLR_HF = 3'd2;
    localparam logic [2:0] S_FGRN   = 3'd3;
    localparam logic [2:0] S_FYEL   = 3'd4;
    localparam logic [2:0] S_CLR_FH = 3'd5;
    localparam logic [2:0] S_FLASH  = 3'd6;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [2:0] OFF = 3'b000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    traffic_light_param_if tl ();

    traffic_light_param #(
        .TW             (16),
        .HW_MIN_GREEN   (8),
        .FARM_MIN_GREEN (4),
        .FARM_MAX_GREEN (10),
        .YEL_TIME       (3),
        .CLR_TIME       (2),
        .FLASH_HALF     (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tl    (tl)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input string field,
                       input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed %b expected %b", tag, field, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] st,
                           input logic [2:0] hw, input logic [2:0] fm);
        chk(tag, "state",   {5'd0, tl.state_o},       {5'd0, st});
        chk(tag, "highway", {5'd0, tl.light_highway}, {5'd0, hw});
        chk(tag, "farm",    {5'd0, tl.light_farm},    {5'd0, fm});
    endtask

    // Advance n clock edges, checking state and lamps 1 ns after each edge.
    task automatic expect_phase(input string tag, input logic [2:0] st,
                                input logic [2:0] hw, input logic [2:0] fm,
                                input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk_all(tag, st, hw, fm);
        end
    endtask

    // Reset with inputs low; release mid-cycle and check the reset outputs.
    task automatic do_reset();
        tl.sensor   = 1'b0;
        tl.flash_en = 1'b0;
        rst_n       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_all("reset", S_HGRN, GRN, RED);
    endtask

    initial begin
        logic [2:0] prev_st;
        int unsigned yel_run;

        tl.sensor   = 1'b0;
        tl.flash_en = 1'b0;

        // 1: idle highway green with no traffic.
        do_reset();
        expect_phase("idle", S_HGRN, GRN, RED, 50);

        // 2: sensor raised one cycle after reset, dropped early in farm green.
        do_reset();
        expect_phase("t2_hgrn_a", S_HGRN, GRN, RED, 1);
        tl.sensor = 1'b1;
        expect_phase("t2_hgrn_b", S_HGRN,   GRN, RED, 6);
        expect_phase("t2_hyel",   S_HYEL,   YEL, RED, 3);
        expect_phase("t2_clr_hf", S_CLR_HF, RED, RED, 2);
        expect_phase("t2_fgrn_a", S_FGRN,   RED, GRN, 2);
        tl.sensor = 1'b0;
        expect_phase("t2_fgrn_b", S_FGRN,   RED, GRN, 2);
        expect_phase("t2_fyel",   S_FYEL,   RED, YEL, 3);
        expect_phase("t2_clr_fh", S_CLR_FH, RED, RED, 2);

        // 3: sensor held high; farm green runs to its maximum, loop repeats.
        tl.sensor = 1'b1;
        expect_phase("t3_hgrn1",  S_HGRN,   GRN, RED, 8);
        expect_phase("t3_hyel1",  S_HYEL,   YEL, RED, 3);
        expect_phase("t3_clr1",   S_CLR_HF, RED, RED, 2);
        expect_phase("t3_fgrn1",  S_FGRN,   RED, GRN, 10);
        expect_phase("t3_fyel1",  S_FYEL,   RED, YEL, 3);
        expect_phase("t3_clrfh1", S_CLR_FH, RED, RED, 2);
        expect_phase("t3_hgrn2",  S_HGRN,   GRN, RED, 8);
        expect_phase("t3_hyel2",  S_HYEL,   YEL, RED, 3);
        expect_phase("t3_clr2",   S_CLR_HF, RED, RED, 2);
        expect_phase("t3_fgrn2",  S_FGRN,   RED, GRN, 10);
        expect_phase("t3_fyel2",  S_FYEL,   RED, YEL, 1);

        // 4: flash request bypasses minimum green, then blinks and resumes.
        do_reset();
        expect_phase("t4_hgrn_a", S_HGRN, GRN, RED, 2);
        tl.flash_en = 1'b1;
        expect_phase("t4_hgrn_b",  S_HGRN,   GRN, RED, 2);
        expect_phase("t4_hyel",    S_HYEL,   YEL, RED, 3);
        expect_phase("t4_clr_hf",  S_CLR_HF, RED, RED, 2);
        expect_phase("t4_lit1",    S_FLASH,  YEL, RED, 2);
        expect_phase("t4_dark1",   S_FLASH,  OFF, OFF, 2);
        expect_phase("t4_lit2",    S_FLASH,  YEL, RED, 2);
        tl.flash_en = 1'b0;
        expect_phase("t4_dark2",   S_FLASH,  OFF, OFF, 2);
        expect_phase("t4_clr_fh",  S_CLR_FH, RED, RED, 2);
        expect_phase("t4_hgrn_c",  S_HGRN,   GRN, RED, 1);

        // 5: asynchronous reset between edges in the middle of farm yellow.
        tl.sensor = 1'b1;
        expect_phase("t5_hgrn",   S_HGRN,   GRN, RED, 7);
        expect_phase("t5_hyel",   S_HYEL,   YEL, RED, 3);
        expect_phase("t5_clr_hf", S_CLR_HF, RED, RED, 2);
        expect_phase("t5_fgrn",   S_FGRN,   RED, GRN, 10);
        expect_phase("t5_fyel",   S_FYEL,   RED, YEL, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all("t5_async_rst", S_HGRN, GRN, RED);
        expect_phase("t5_rst_held", S_HGRN, GRN, RED, 1);
        #2;
        rst_n = 1'b1;

        // 6: random inputs with safety, encoding and yellow-length checks.
        tl.sensor   = 1'b0;
        tl.flash_en = 1'b0;
        prev_st = tl.state_o;
        yel_run = 0;
        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(0, 19) == 0)
                tl.sensor = ~tl.sensor;
            if ($urandom_range(0, 299) == 0)
                tl.flash_en = ~tl.flash_en;
            @(posedge clk);
            #1;
            chk("rand", "hw_onehot0", {7'd0, $onehot0(tl.light_highway)}, 8'd1);
            chk("rand", "fm_onehot0", {7'd0, $onehot0(tl.light_farm)}, 8'd1);
            chk("rand", "state_range", {7'd0, (tl.state_o <= S_FLASH)}, 8'd1);
            if (tl.state_o == S_FLASH) begin
                chk("rand", "flash_hw",
                    {7'd0, (tl.light_highway == YEL) || (tl.light_highway == OFF)}, 8'd1);
                chk("rand", "flash_fm",
                    {7'd0, (tl.light_farm == RED) || (tl.light_farm == OFF)}, 8'd1);
            end else begin
                chk("rand", "both_non_red",
                    {7'd0, (tl.light_highway != RED) && (tl.light_farm != RED)}, 8'd0);
            end
            if ((tl.state_o == S_HYEL) || (tl.state_o == S_FYEL)) begin
                if (tl.state_o == prev_st)
                    yel_run++;
                else
                    yel_run = 1;
            end else if ((prev_st == S_HYEL) || (prev_st == S_FYEL)) begin
                chk("rand", "yellow_len", 8'(yel_run), 8'd3);
                yel_run = 0;
            end
            prev_st = tl.state_o;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
